// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: SPARC load/store opcodes, RAM access
// sizes, sequencer state encoding and small opcode classification helpers.
package mem_pkg;

  localparam logic [3:0] OP_LDSB   = 4'd0;
  localparam logic [3:0] OP_LDSH   = 4'd1;
  localparam logic [3:0] OP_LDUB   = 4'd2;
  localparam logic [3:0] OP_LDUH   = 4'd3;
  localparam logic [3:0] OP_LD     = 4'd4;
  localparam logic [3:0] OP_LDD    = 4'd5;
  localparam logic [3:0] OP_STB    = 4'd6;
  localparam logic [3:0] OP_STH    = 4'd7;
  localparam logic [3:0] OP_ST     = 4'd8;
  localparam logic [3:0] OP_STD    = 4'd9;
  localparam logic [3:0] OP_LDSTUB = 4'd10;
  localparam logic [3:0] OP_SWAP   = 4'd11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Size of the first RAM access issued for an opcode.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LDSB, OP_LDUB, OP_STB, OP_LDSTUB: op_size = SZ_BYTE;
      OP_LDSH, OP_LDUH, OP_STH:            op_size = SZ_HALF;
      default:                             op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op == OP_STB) || (op == OP_STH) || (op == OP_ST) || (op == OP_STD);
  endfunction

  function automatic logic is_dual(input logic [3:0] op);
    is_dual = (op == OP_LDD) || (op == OP_STD) || (op == OP_LDSTUB) || (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment / opcode legality check for a load/store request.
// Only the low three address bits can ever make an access misaligned.
import mem_pkg::*;

module mem_align_check (
  input  logic [3:0] op_i,
  input  logic [2:0] addr_i,
  output logic       misaligned_o,
  output logic       illegal_o
);

  always_comb begin
    misaligned_o = 1'b0;
    illegal_o    = (op_i > OP_SWAP);
    case (op_i)
      OP_LDSH, OP_LDUH, OP_STH: misaligned_o = addr_i[0];
      OP_LD, OP_ST, OP_SWAP:    misaligned_o = |addr_i[1:0];
      OP_LDD, OP_STD:           misaligned_o = |addr_i[2:0];
      default:                  misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: accepts one load/store request, drives the byte-addressed
// data RAM over one or two access cycles and returns a single registered response.
import mem_pkg::*;

module load_store_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wdata2,
  output logic [ADDR_W-1:0] ram_A,
  output logic [DATA_W-1:0] ram_DI,
  output logic [1:0]        ram_Size,
  output logic              ram_RW,
  output logic              ram_E,
  output logic              ram_SE,
  input  logic [DATA_W-1:0] ram_DO,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              trap_align,
  output logic              trap_illop
);

  state_e            state_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata2_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] rsp_data2_q;
  logic              trap_align_q;
  logic              trap_illop_q;

  logic              misaligned;
  logic              illegal;
  logic [DATA_W-1:0] load_d;
  logic              ram_e_raw;

  mem_align_check u_align (
    .op_i         (req_op),
    .addr_i       (req_addr[2:0]),
    .misaligned_o (misaligned),
    .illegal_o    (illegal)
  );

  // Re-extend locally so the result does not depend on the RAM honouring SE.
  function automatic logic [DATA_W-1:0] ext_load(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] d);
    case (op)
      OP_LDSB:           ext_load = {{(DATA_W-8){d[7]}}, d[7:0]};
      OP_LDSH:           ext_load = {{(DATA_W-16){d[15]}}, d[15:0]};
      OP_LDUB, OP_LDSTUB: ext_load = {{(DATA_W-8){1'b0}}, d[7:0]};
      OP_LDUH:           ext_load = {{(DATA_W-16){1'b0}}, d[15:0]};
      default:           ext_load = d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] fit_wdata(input logic [1:0] sz,
                                                  input logic [DATA_W-1:0] w);
    case (sz)
      SZ_BYTE: fit_wdata = {{(DATA_W-8){1'b0}}, w[7:0]};
      SZ_HALF: fit_wdata = {{(DATA_W-16){1'b0}}, w[15:0]};
      default: fit_wdata = w;
    endcase
  endfunction

  assign load_d = ext_load(op_q, ram_DO);

  // RAM port decode from registered state only; all zero outside the access cycles.
  always_comb begin
    ram_A     = '0;
    ram_DI    = '0;
    ram_Size  = SZ_BYTE;
    ram_RW    = 1'b0;
    ram_e_raw = 1'b0;
    ram_SE    = 1'b0;
    case (state_q)
      ST_ACC0: begin
        ram_e_raw = 1'b1;
        ram_A     = addr_q;
        ram_Size  = op_size(op_q);
        ram_SE    = (op_q == OP_LDSB) || (op_q == OP_LDSH);
        if (is_store(op_q)) begin
          ram_RW = 1'b1;
          ram_DI = fit_wdata(op_size(op_q), wdata_q);
        end
      end
      ST_ACC1: begin
        ram_e_raw = 1'b1;
        case (op_q)
          OP_LDD: begin
            ram_A    = addr_q + ADDR_W'(4);
            ram_Size = SZ_WORD;
          end
          OP_STD: begin
            ram_A    = addr_q + ADDR_W'(4);
            ram_Size = SZ_WORD;
            ram_RW   = 1'b1;
            ram_DI   = wdata2_q;
          end
          OP_LDSTUB: begin
            ram_A    = addr_q;
            ram_Size = SZ_BYTE;
            ram_RW   = 1'b1;
            ram_DI   = DATA_W'(8'hFF);
          end
          default: begin
            ram_A    = addr_q;
            ram_Size = SZ_WORD;
            ram_RW   = 1'b1;
            ram_DI   = wdata_q;
          end
        endcase
      end
      default: ;
    endcase
    ram_E = ram_e_raw & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wdata2_q     <= '0;
      rsp_data_q   <= '0;
      rsp_data2_q  <= '0;
      trap_align_q <= 1'b0;
      trap_illop_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q         <= req_op;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            wdata2_q     <= req_wdata2;
            rsp_data_q   <= '0;
            rsp_data2_q  <= '0;
            trap_illop_q <= illegal;
            trap_align_q <= ~illegal & misaligned;
            state_q      <= (illegal || misaligned) ? ST_RESP : ST_ACC0;
          end
        end
        ST_ACC0: begin
          if (!is_store(op_q)) rsp_data_q <= load_d;
          state_q <= is_dual(op_q) ? ST_ACC1 : ST_RESP;
        end
        ST_ACC1: begin
          if (op_q == OP_LDD) rsp_data2_q <= ram_DO;
          state_q <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_data2  = rsp_data2_q;
  assign trap_align = trap_align_q;
  assign trap_illop = trap_illop_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a big-endian byte RAM model,
// directed vector table, multi-cycle corner sequences and a randomized reference model.
module tb_load_store_unit;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wdata2;
  logic [ADDR_W-1:0] ram_A;
  logic [DATA_W-1:0] ram_DI;
  logic [1:0]        ram_Size;
  logic              ram_RW;
  logic              ram_E;
  logic              ram_SE;
  logic [DATA_W-1:0] ram_DO;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] rsp_data2;
  logic              trap_align;
  logic              trap_illop;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_wdata2(req_wdata2),
    .ram_A(ram_A), .ram_DI(ram_DI), .ram_Size(ram_Size), .ram_RW(ram_RW),
    .ram_E(ram_E), .ram_SE(ram_SE), .ram_DO(ram_DO), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_data2(rsp_data2), .trap_align(trap_align),
    .trap_illop(trap_illop)
  );

  always #5 clk = ~clk;

  // RAM seen by the DUT (big-endian, writes on posedge when enabled)
  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  int e_cnt = 0;
  int rsp_cnt = 0;

  always @(posedge clk) begin
    if (ram_E) e_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (ram_E && ram_RW) begin
      case (ram_Size)
        2'b00: mem[int'(ram_A)] <= ram_DI[7:0];
        2'b01: begin
          mem[int'(ram_A)]             <= ram_DI[15:8];
          mem[(int'(ram_A) + 1) % 512] <= ram_DI[7:0];
        end
        default: begin
          mem[int'(ram_A)]             <= ram_DI[31:24];
          mem[(int'(ram_A) + 1) % 512] <= ram_DI[23:16];
          mem[(int'(ram_A) + 2) % 512] <= ram_DI[15:8];
          mem[(int'(ram_A) + 3) % 512] <= ram_DI[7:0];
        end
      endcase
    end
  end

  always_comb begin
    ram_DO = '0;
    case (ram_Size)
      2'b00: ram_DO = ram_SE ? {{24{mem[int'(ram_A)][7]}}, mem[int'(ram_A)]}
                             : {24'h0, mem[int'(ram_A)]};
      2'b01: ram_DO = ram_SE ? {{16{mem[int'(ram_A)][7]}}, mem[int'(ram_A)], mem[(int'(ram_A)+1)%512]}
                             : {16'h0, mem[int'(ram_A)], mem[(int'(ram_A)+1)%512]};
      default: ram_DO = {mem[int'(ram_A)], mem[(int'(ram_A)+1)%512],
                         mem[(int'(ram_A)+2)%512], mem[(int'(ram_A)+3)%512]};
    endcase
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (architectural rules on ref_mem) ----------------
  function automatic int rd32(input int a);
    return (int'(ref_mem[a]) << 24) | (int'(ref_mem[a+1]) << 16) |
           (int'(ref_mem[a+2]) << 8) | int'(ref_mem[a+3]);
  endfunction

  task automatic wr32(input int a, input logic [31:0] v);
    ref_mem[a] = v[31:24]; ref_mem[a+1] = v[23:16];
    ref_mem[a+2] = v[15:8]; ref_mem[a+3] = v[7:0];
  endtask

  task automatic ref_exec(input logic [3:0] op, input int a, input logic [31:0] wd,
                          input logic [31:0] wd2, output logic [31:0] d,
                          output logic [31:0] d2, output logic ta, output logic ti,
                          output int lat);
    int h;
    d = 0; d2 = 0; ta = 0; ti = 0;
    if (op > 11) ti = 1;
    else if ((op == 1 || op == 3 || op == 7) && (a % 2 != 0)) ta = 1;
    else if ((op == 4 || op == 8 || op == 11) && (a % 4 != 0)) ta = 1;
    else if ((op == 5 || op == 9) && (a % 8 != 0)) ta = 1;
    if (ti || ta) lat = 1;
    else begin
      lat = (op == 5 || op == 9 || op == 10 || op == 11) ? 3 : 2;
      h = int'(ref_mem[a]) * 256 + int'(ref_mem[(a+1)%512]);
      case (op)
        0:  d = (ref_mem[a] >= 128) ? 32'(int'(ref_mem[a]) - 256) : 32'(ref_mem[a]);
        1:  d = (h >= 32768) ? 32'(h - 65536) : 32'(h);
        2:  d = 32'(ref_mem[a]);
        3:  d = 32'(h);
        4:  d = rd32(a);
        5:  begin d = rd32(a); d2 = rd32(a + 4); end
        6:  ref_mem[a] = wd[7:0];
        7:  begin ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0]; end
        8:  wr32(a, wd);
        9:  begin wr32(a, wd); wr32(a + 4, wd2); end
        10: begin d = 32'(ref_mem[a]); ref_mem[a] = 8'hFF; end
        default: begin d = rd32(a); wr32(a, wd); end
      endcase
    end
  endtask

  // ---------------- request driver ----------------
  logic [31:0] g_d, g_d2, m_d, m_d2;
  logic        g_ta, g_ti, m_ta, m_ti;
  int          g_lat, m_lat, g_e;

  task automatic do_req(input logic [3:0] op, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] wd2);
    int e0;
    for (int i = 0; i < 20 && !req_ready; i++) begin @(posedge clk); #1; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    ref_exec(op, int'(a), wd, wd2, m_d, m_d2, m_ta, m_ti, m_lat);
    req_valid = 1; req_op = op; req_addr = a; req_wdata = wd; req_wdata2 = wd2;
    e0 = e_cnt;
    @(posedge clk); #1;
    req_valid = 0;
    g_lat = 1;
    while (!rsp_valid && g_lat < 10) begin @(posedge clk); #1; g_lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    g_d = rsp_data; g_d2 = rsp_data2; g_ta = trap_align; g_ti = trap_illop;
    g_e = e_cnt - e0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [8:0]  addr;
    logic [31:0] wd, wd2, ed, ed2;
    logic        ea, ei;
    int          lat;
  } vec_t;

  vec_t tv [14];

  initial begin
    logic [8:0] pat_r, pat_q;
    int ok_cnt, rc0;
    logic [3:0] rop;
    logic [8:0] ra;
    int diffs;

    for (int i = 0; i < 512; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    reset = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_wdata2 = 0;

    tv[0]  = '{4'd7,  9'h040, 32'h0000BEEF, 32'h0, 32'h0,        32'h0,        1'b0, 1'b0, 2};
    tv[1]  = '{4'd1,  9'h040, 32'h0,        32'h0, 32'hFFFFBEEF, 32'h0,        1'b0, 1'b0, 2};
    tv[2]  = '{4'd3,  9'h040, 32'h0,        32'h0, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 2};
    tv[3]  = '{4'd9,  9'h100, 32'h11223344, 32'h55667788, 32'h0, 32'h0,        1'b0, 1'b0, 3};
    tv[4]  = '{4'd5,  9'h100, 32'h0,        32'h0, 32'h11223344, 32'h55667788, 1'b0, 1'b0, 3};
    tv[5]  = '{4'd6,  9'h020, 32'h0000005A, 32'h0, 32'h0,        32'h0,        1'b0, 1'b0, 2};
    tv[6]  = '{4'd10, 9'h020, 32'h0,        32'h0, 32'h0000005A, 32'h0,        1'b0, 1'b0, 3};
    tv[7]  = '{4'd2,  9'h020, 32'h0,        32'h0, 32'h000000FF, 32'h0,        1'b0, 1'b0, 2};
    tv[8]  = '{4'd4,  9'h042, 32'h0,        32'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    tv[9]  = '{4'd5,  9'h104, 32'h0,        32'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    tv[10] = '{4'd14, 9'h000, 32'h0,        32'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1};
    tv[11] = '{4'd7,  9'h041, 32'h00001234, 32'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    tv[12] = '{4'd0,  9'h040, 32'h0,        32'h0, 32'hFFFFFFBE, 32'h0,        1'b0, 1'b0, 2};
    tv[13] = '{4'd4,  9'h040, 32'h0,        32'h0, 32'hBEEF0000, 32'h0,        1'b0, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ramE",  32'(ram_E), 32'd0);
    chk("rst_data",  rsp_data, 32'd0);
    chk("rst_traps", {30'd0, trap_align, trap_illop}, 32'd0);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      do_req(tv[i].op, tv[i].addr, tv[i].wd, tv[i].wd2);
      chk($sformatf("tv%0d_data", i),  g_d,  tv[i].ed);
      chk($sformatf("tv%0d_data2", i), g_d2, tv[i].ed2);
      chk($sformatf("tv%0d_traps", i), {30'd0, g_ta, g_ti}, {30'd0, tv[i].ea, tv[i].ei});
      chk($sformatf("tv%0d_lat", i),   32'(g_lat), 32'(tv[i].lat));
      if (tv[i].ea || tv[i].ei) chk($sformatf("tv%0d_noE", i), 32'(g_e), 32'd0);
    end

    // Back-to-back with req_valid held high
    for (int i = 0; i < 20 && !req_ready; i++) begin @(posedge clk); #1; end
    req_valid = 1; req_op = 4'd4; req_addr = 9'h040; req_wdata = 0; req_wdata2 = 0;
    pat_r = 0; pat_q = 0; ok_cnt = 0;
    for (int s = 0; s < 9; s++) begin
      @(posedge clk); #1;
      pat_r[s] = rsp_valid; pat_q[s] = req_ready;
      if (rsp_valid && rsp_data == 32'hBEEF0000) ok_cnt++;
    end
    req_valid = 0;
    chk("b2b_rsp_pattern", 32'(pat_r), 32'(9'b010010010));
    chk("b2b_ready_pattern", 32'(pat_q), 32'(9'b100100100));
    chk("b2b_data_count", 32'(ok_cnt), 32'd3);

    // SWAP aborted by reset in its ACC1 cycle
    do_req(4'd8, 9'h080, 32'h01020304, 32'h0);
    for (int i = 0; i < 20 && !req_ready; i++) begin @(posedge clk); #1; end
    rc0 = rsp_cnt;
    req_valid = 1; req_op = 4'd11; req_addr = 9'h080; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("swap_rst_ready", 32'(req_ready), 32'd1);
    chk("swap_rst_data", rsp_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("swap_rst_norsp", 32'(rsp_cnt - rc0), 32'd0);
    chk("swap_rst_mem", {mem[128], mem[129], mem[130], mem[131]}, 32'h01020304);

    // Randomized against reference model
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 9'($urandom);
      if ($urandom_range(0, 3) != 0) ra = ra & 9'h1F8;
      do_req(rop, ra, $urandom, $urandom);
      chk($sformatf("rnd%0d_op%0d_data", n, rop), g_d, m_d);
      chk($sformatf("rnd%0d_data2", n), g_d2, m_d2);
      chk($sformatf("rnd%0d_traps", n), {30'd0, g_ta, g_ti}, {30'd0, m_ta, m_ti});
      chk($sformatf("rnd%0d_lat", n), 32'(g_lat), 32'(m_lat));
    end
    @(posedge clk); #1;
    diffs = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("final_mem_diffs", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage sequencer placed directly upstream of the byte-addressed data RAM. It accepts one SPARC load/store request at a time from the pipeline over a valid/ready handshake and checks alignment. It drives the RAM control/data ports (A, DI, Size, RW, E, SE) and returns a registered, sign-/zero-extended result. Multi-access instructions (LDD, STD, LDSTUB, SWAP) run as short state-machine sequences, so the pipeline sees a single request and a single response.

## Interface
- ADDR_W, 9: byte-address width; matches the RAM's 512-byte array.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; the RAM writes on the same posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_op  in  4  opcode (encodings in mem_pkg).
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  DATA_W  store data (even register for STD, source register for SWAP).
- req_wdata2  in  DATA_W  odd-register store data for STD.
- ram_A  out  ADDR_W  RAM byte address.
- ram_DI  out  DATA_W  RAM write data.
- ram_Size  out  2  00 byte, 01 halfword, 10 word.
- ram_RW  out  1  0 read, 1 write.
- ram_E  out  1  RAM enable.
- ram_SE  out  1  sign extend.
- ram_DO  in  DATA_W  RAM combinational read data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  load result (even word for LDD; old memory value for LDSTUB/SWAP).
- rsp_data2  out  DATA_W  odd word for LDD; 0 for every other op.
- trap_align  out  1  valid with rsp_valid: mem_address_not_aligned.
- trap_illop  out  1  valid with rsp_valid: unknown opcode.

## Operation
- Opcodes: LDSB 0, LDSH 1, LDUB 2, LDUH 3, LD 4, LDD 5, STB 6, STH 7, ST 8, STD 9, LDSTUB 10, SWAP 11. Codes 12–15 are illegal.
- Alignment rules:
  - Halfword ops require addr[0]=0.
  - Word ops (LD, ST, SWAP) require addr[1:0]=0.
  - LDD and STD require addr[2:0]=0.
  - Byte ops and LDSTUB are always aligned.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr, wdata and wdata2, and clear rsp_data, rsp_data2 and both traps.
  - Misaligned or illegal request: go to RESP with the matching trap set and no RAM access.
  - Otherwise go to ACC0.
- ACC0 (first access, at the latched addr):
  - Loads read; ram_DO is captured into rsp_data at the cycle-ending edge.
  - Stores write wdata at the op size.
  - LDSTUB and SWAP perform a read (byte, unsigned / word) and capture it.
  - LDD, STD, LDSTUB and SWAP then go to ACC1; all other ops go to RESP.
- ACC1 (second access):
  - LDD reads the word at addr+4 into rsp_data2.
  - STD writes wdata2 at addr+4.
  - LDSTUB writes byte 8'hFF at addr.
  - SWAP writes wdata as a word at addr.
  - Then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- ram_SE=1 only for LDSB and LDSH.
- Outside ACC0/ACC1: ram_E=0, and ram_A, ram_DI, ram_Size, ram_RW, ram_SE are all 0.
- addr+4 is computed in ADDR_W bits. It cannot wrap, because 8-byte alignment bounds addr to at most 504.

## Timing
- All RAM port outputs are Moore (decoded from registered state and latches) and are valid for the whole ACC cycle.
- ram_E is additionally gated by !reset, so no RAM write occurs on an edge where reset=1.
- Latency from the accept edge to the rsp_valid cycle:
  - Misaligned or illegal: 1 cycle.
  - Single-access ops: 2 cycles.
  - LDD, STD, LDSTUB, SWAP: 3 cycles.
- Throughput: next accept in the cycle after RESP; req_ready is 0 from the accept edge through RESP.
- Reset values: state IDLE; req_ready=1 after reset. All other outputs and result registers are 0.
- Reset during ACC0/ACC1/RESP:
  - The operation is aborted and no response is issued.
  - A second access of LDD, STD, LDSTUB or SWAP not yet performed never happens. For LDSTUB/SWAP this means memory keeps its old value.
- A request presented while req_ready=0 is ignored. Upstream holds it until accepted.

## Structure
- Shared package mem_pkg holds:
  - opcode localparams;
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encoding.
- Sub-module mem_align_check (combinational): op and addr in, misaligned and illegal flags out. It is reused later by the trap unit.
- The RAM itself is not instantiated here. It connects at the top level.

## Test plan
- STH 16'hBEEF @ 0x40, then LDSH @ 0x40 → rsp_data=32'hFFFFBEEF. Then LDUH @ 0x40 → 32'h0000BEEF, with rsp_valid 2 cycles after accept.
- STD wdata=32'h11223344, wdata2=32'h55667788 @ 0x100, then LDD @ 0x100 → rsp_data=32'h11223344, rsp_data2=32'h55667788, 3-cycle latency.
- Mem[0x20]=8'h5A, LDSTUB @ 0x20 → rsp_data=32'h5A; subsequent LDUB @ 0x20 → 32'hFF.
- LD @ 0x42 and LDD @ 0x104 → trap_align=1 one cycle after accept, ram_E never 1, memory unchanged. Opcode 14 → trap_illop=1.
- SWAP wdata=32'hCAFEF00D @ 0x80 (old 32'h01020304), with reset asserted in the ACC1 cycle → no rsp_valid, Mem[0x80..0x83] stays 01 02 03 04, req_ready=1 after reset.
- Back-to-back requests with req_valid held high → second accepted in the cycle after RESP; no request is lost or duplicated.
